// File: rtl/sequencia_pkg.sv
// Shared definitions for the sequencia serial pattern transmitter.
// Contents:
//   state_e    - transmitter FSM states (IDLE, ARM, PRE, SEND, DONE)
//   WIDTH_DEF  - default bits per transmitted word
//   LFSR_SEED  - reset value of the optional preamble LFSR
//   LFSR_TAPS  - feedback mask for taps 8,6,5,4 (bits 7,5,4,3)
//   lfsr_next  - one Fibonacci LFSR step, shifting left
// The LFSR items are only consumed when SEQUENCIA_TX_LFSR_EN is defined.
package sequencia_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PRE,
    ST_SEND,
    ST_DONE
  } state_e;

  // Feedback is the XOR of the tapped bits; it enters at bit 0 so the
  // oldest bit leaves through bit 7.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sequencia_tx_if.sv
// Interface bundling the configuration, trigger and serial output signals
// of the sequencia transmitter.
// Signals:
//   setar_palavra, palavra      - word register write strobe and data
//   setar_prefixo, prefixo_len  - preamble length write strobe and data
//   start                       - level trigger (rising edge starts a frame)
//   start_out, bit_out, bit_valid, ocupado, concluido - transmitter outputs
// Modports:
//   master - the controlling side (drives config/start, observes outputs)
//   slave  - the transmitter itself
interface sequencia_tx_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);

  logic             setar_palavra;
  logic [WIDTH-1:0] palavra;
  logic             setar_prefixo;
  logic [PRE_W-1:0] prefixo_len;
  logic             start;
  logic             start_out;
  logic             bit_out;
  logic             bit_valid;
  logic             ocupado;
  logic             concluido;

  modport master (
    output setar_palavra, palavra, setar_prefixo, prefixo_len, start,
    input  start_out, bit_out, bit_valid, ocupado, concluido
  );

  modport slave (
    input  setar_palavra, palavra, setar_prefixo, prefixo_len, start,
    output start_out, bit_out, bit_valid, ocupado, concluido
  );

endinterface

// File: rtl/sequencia_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the preamble filler source.
// Only compiled when SEQUENCIA_TX_LFSR_EN is defined.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, reseeds to LFSR_SEED
//   en_i   - advance one step at this edge
//   bit_o  - current filler bit (state bit 7)
`ifdef SEQUENCIA_TX_LFSR_EN
module sequencia_lfsr
  import sequencia_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign bit_o = lfsr_q[7];

endmodule
`endif

// File: rtl/sequencia_tx.sv
// Serial pattern transmitter. On a rising edge of bus.start it raises the
// framing strobe, waits one ARM cycle, sends prefixo_len filler bits and
// then the programmed word MSB-first, one bit per clock, and pulses
// concluido after the last bit.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears all state and outputs
//   bus    - sequencia_tx_if.slave (configuration, trigger, serial outputs)
// Build option:
//   SEQUENCIA_TX_LFSR_EN - filler bits come from an 8-bit LFSR instead of 0.
module sequencia_tx
  import sequencia_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sequencia_tx_if.slave   bus
);

  // One down-counter serves both the preamble and the word phase, so it
  // must hold either the largest preamble length or WIDTH-1.
  localparam int CNT_W = (PRE_W > $clog2(WIDTH)) ? PRE_W : $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             start_prev_q;
  logic [WIDTH-1:0] word_q, word_d;
  logic [PRE_W-1:0] pre_len_q, pre_len_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_out_q, start_out_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             ocupado_q, ocupado_d;
  logic             concluido_q, concluido_d;
  logic             start_rise;
  logic             filler;

  assign start_rise = bus.start & ~start_prev_q;

`ifdef SEQUENCIA_TX_LFSR_EN
  // The LFSR steps on exactly those edges that load a filler bit into
  // bit_out, so each emitted filler bit consumes one LFSR state.
  logic fill_en;

  assign fill_en = ((state_q == ST_ARM) && (cnt_q != '0)) ||
                   ((state_q == ST_PRE) && (cnt_q != CNT_W'(1)));

  sequencia_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (fill_en),
    .bit_o (filler)
  );
`else
  assign filler = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    word_d      = bus.setar_palavra ? bus.palavra     : word_q;
    pre_len_d   = bus.setar_prefixo ? bus.prefixo_len : pre_len_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    start_out_d = start_out_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Latching uses the pre-write register values, so a write in the
        // same cycle as the trigger only affects the following frame.
        if (start_rise) begin
          state_d     = ST_ARM;
          start_out_d = 1'b1;
          ocupado_d   = 1'b1;
          shift_d     = word_q;
          cnt_d       = CNT_W'(pre_len_q);
        end
      end

      ST_ARM: begin
        bit_valid_d = 1'b1;
        if (cnt_q != '0) begin
          state_d   = ST_PRE;
          bit_out_d = filler;
        end else begin
          state_d   = ST_SEND;
          bit_out_d = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d     = CNT_W'(WIDTH - 1);
        end
      end

      ST_PRE: begin
        // cnt_q counts the filler bits still to be shown, including the
        // one currently on bit_out.
        if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_SEND;
          bit_out_d = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d     = CNT_W'(WIDTH - 1);
        end else begin
          bit_out_d = filler;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end

      ST_SEND: begin
        // cnt_q counts the word bits still to come after the current one.
        if (cnt_q == '0) begin
          state_d     = ST_DONE;
          start_out_d = 1'b0;
          bit_valid_d = 1'b0;
          bit_out_d   = 1'b0;
          concluido_d = 1'b1;
        end else begin
          bit_out_d = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        ocupado_d = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        start_out_d = 1'b0;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        ocupado_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      word_q       <= '0;
      pre_len_q    <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      start_out_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      ocupado_q    <= 1'b0;
      concluido_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= bus.start;
      word_q       <= word_d;
      pre_len_q    <= pre_len_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      start_out_q  <= start_out_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      ocupado_q    <= ocupado_d;
      concluido_q  <= concluido_d;
    end
  end

  assign bus.start_out = start_out_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.concluido = concluido_q;

endmodule

// File: doc/sequencia_tx.md
Name: sequencia_tx

Overview:
- Serial pattern transmitter; the driving end of the bit-serial word-detection interface.
- Holds a programmed 8-bit target word and a programmable-length preamble.
- On a rising edge of `start` it raises a framing strobe, sends the preamble filler bits, then the word MSB-first, one bit per clock, and reports completion.
- Its outputs connect directly to a detector's `start` and `bit_in` pins, both in the bench and in loopback self-test.

Parameters:
- WIDTH, 8, bits per transmitted word.
- PRE_W, 4, width of the preamble length field. Maximum preamble is 2^PRE_W-1 bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- setar_palavra  in  1  load `palavra` into the word register this cycle.
- palavra  in  WIDTH  word to transmit.
- setar_prefixo  in  1  load `prefixo_len` into the preamble-length register this cycle.
- prefixo_len  in  PRE_W  number of filler bits sent before the word (0 is allowed).
- start  in  1  level input; only its rising edge triggers a frame.
- start_out  out  1  framing strobe, high for the whole frame; drives the detector's `start`.
- bit_out  out  1  serial data; drives the detector's `bit_in`.
- bit_valid  out  1  high on every cycle in which `bit_out` carries a frame bit.
- ocupado  out  1  high from the trigger edge until `concluido`, inclusive.
- concluido  out  1  one-cycle pulse after the last word bit.

Behaviour:
- Reset:
  - Asserting `rst_n` low clears everything immediately, mid-frame included: word register = 0, preamble length = 0, start_prev = 0, FSM = IDLE, bit counter = 0, and all outputs = 0.
  - No partial frame resumes after reset is released.
- Configuration registers:
  - `setar_palavra` and `setar_prefixo` are accepted in any state.
  - A frame copies both registers into working copies at its trigger edge. Writes made mid-frame affect only the next frame.
- Edge detection:
  - start_rise = start & ~start_prev.
  - start_prev updates every cycle in every state.
  - A rise seen while not in IDLE is ignored and is not queued.
- FSM states: IDLE, ARM, PRE, SEND, DONE. All outputs are registered.
- IDLE:
  - On start_rise at edge E0: start_out <= 1, ocupado <= 1, latch the word and preamble length, go to ARM.
- ARM:
  - Lasts exactly one cycle, with bit_valid = 0. This gives the detector one cycle to see its own start rise and clear.
  - At edge E1: go to PRE if the latched length > 0, otherwise go to SEND.
  - In the same edge, drive the first bit: bit_valid <= 1 and bit_out <= first filler bit (PRE) or word[WIDTH-1] (SEND).
- PRE:
  - Emits exactly the latched number of filler bits, one per cycle. Filler value is 0 (default build).
  - Counter counts down to 1, then the FSM enters SEND with word[WIDTH-1] on the next edge.
- SEND:
  - Emits word[WIDTH-1] down to word[0], one per cycle, via a left-shifting shift register.
  - After word[0] has been held for one cycle, go to DONE.
- DONE:
  - Lasts one cycle: start_out <= 0, bit_valid <= 0, bit_out <= 0, concluido = 1. ocupado stays 1 during this cycle.
  - Next edge returns to IDLE with ocupado <= 0.
- Timing:
  - With the word register set to 8'hB5 and preamble length P, bit_valid is high for P+WIDTH consecutive cycles starting at E1.
  - concluido rises at edge E0+P+WIDTH+1.
  - A new frame can trigger on the cycle after DONE, provided `start` was seen low at some edge before it.
- Simultaneous events:
  - start_rise together with setar_palavra in IDLE: the frame sends the old word. The register update lands at the same edge as the latch.
- Boundary condition: the all-zero word with a zero-filled preamble is legal. The receiver may match early, which is the receiver's concern.

Optional Feature:
- Macro: SEQUENCIA_TX_LFSR_EN.
- When defined:
  - Preamble filler comes from an 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded 8'hA5 by reset.
  - The LFSR advances only on cycles that emit a PRE bit.
  - The emitted bit is lfsr[7].
- When undefined:
  - No LFSR logic exists.
  - Filler bits are 0.

Decomposition:
- Shared package `sequencia_pkg`:
  - FSM state enum (IDLE, ARM, PRE, SEND, DONE).
  - WIDTH default.
  - LFSR seed 8'hA5 and tap mask.
- One natural sub-module, `sequencia_lfsr`: 8-bit LFSR with enable, present only under SEQUENCIA_TX_LFSR_EN.
- Everything else stays flat in `sequencia_tx`.

Test Plan:
1. Reset, word=8'hB5, length=0, pulse `start` → start_out high one cycle before bit_valid, then bit_out = 1,0,1,1,0,1,0,1 on 8 consecutive cycles, then concluido pulses once and ocupado falls.
2. Word=8'h3C, length=3, default build → 3 zero bits, then 0,0,1,1,1,1,0,0. Loopback into the detector programmed with 8'h3C → detector's `encontrado`=1 one edge after the last bit.
3. setar_palavra with 8'hFF during SEND of 8'h01 → the current frame still sends 8'h01, and the next frame sends 8'hFF.
4. Second rise of `start` mid-frame, then `start` held high after DONE → no retrigger and no extra frame. A new rise after `start` returns low starts exactly one frame.
5. Drop rst_n during the 5th word bit → all outputs 0 asynchronously. After release, IDLE, and the word register reads back as 0 (frame sends 8'h00).
6. With SEQUENCIA_TX_LFSR_EN, length=8 → filler equals the 8 MSBs of the LFSR sequence from seed 8'hA5, matching a reference model. The second frame continues the LFSR sequence rather than reseeding.
